// File: rtl/serial_shift_engine.sv
// serial_shift_engine
// Multi-cycle variable-distance shifter. Each request is shifted one bit per
// clock, in_amt times, then held on the output until the consumer takes it.
//
// Handshake semantics (both ports): a transfer happens on the rising edge where
// valid && ready are both high. Valid, once raised by the engine, stays high
// with stable data until that edge. in_ready and out_valid come only from the
// state register, gated by rst, so neither depends combinationally on in_* or
// on out_ready.
module serial_shift_engine #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5  // WIDTH must equal 2**AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [AMT_W-1:0]   cnt_q;
    logic [AMT_W-1:0]   cnt_d;
    logic               dir_q;
    logic               dir_d;
    logic               arith_q;
    logic               arith_d;
    logic [WIDTH-1:0]   shifted;
    logic               accept;
    logic               release_out;

    // One-bit shift of the held value; right shifts fill with the old MSB
    // only when the request asked for an arithmetic shift.
    always_comb begin
        shifted = data_q;
        if (dir_q) begin
            shifted = {(arith_q & data_q[WIDTH-1]), data_q[WIDTH-1:1]};
        end else begin
            shifted = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    // Handshake decode from the state register; rst masks both sides so no
    // transfer can be seen in a reset cycle.
    always_comb begin
        in_ready    = (state_q == IDLE) && !rst;
        out_valid   = (state_q == DONE) && !rst;
        accept      = in_ready && in_valid;
        release_out = out_valid && out_ready;
        busy        = (state_q != IDLE);
        out_data    = data_q;
        dbg_state   = state_q;
    end

    // Next-state and datapath update; zero-amount requests skip SHIFT so the
    // counter never has to decrement past zero.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = in_amt;
                    dir_d   = in_dir;
                    arith_d = in_arith;
                    if (in_amt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                data_d = shifted;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed bench for serial_shift_engine: a vector table of single requests
// plus hand-written backpressure and mid-shift reset sequences.
module tb_serial_shift_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_dir;
  logic [4:0]  in_amt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        dir;
    logic [4:0]  amt;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  serial_shift_engine #(.WIDTH(32), .AMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Waits (bounded) for a negedge where the engine is ready.
  task automatic wait_ready(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) check({nm, " ready timeout"}, 32'(got), 32'd1);
  endtask

  // Waits (bounded) for out_valid; returns number of negedges waited.
  task automatic wait_valid(output logic got, output int lat, output int bcnt);
    got = 1'b0; lat = 0; bcnt = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid) got = 1'b1;
    end
  endtask

  // One request with out_ready high: checks result, latency, busy, release.
  task automatic run_req(input string nm, input logic [31:0] d, input logic dir,
                         input logic [4:0] amt, input logic arith, input logic [31:0] exp);
    logic got;
    int lat, bcnt;
    logic [31:0] e;
    wait_ready(nm);
    in_valid = 1'b1; in_data = d; in_dir = dir; in_amt = amt; in_arith = arith;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(got, lat, bcnt);
    check({nm, " out_valid seen"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check({nm, " data"}, out_data, e);
      check({nm, " latency"}, 32'(lat), 32'(amt) + 32'd1);
      check({nm, " busy cycles"}, 32'(bcnt), 32'(amt) + 32'd1);
      @(negedge clk);
      check({nm, " released valid"}, 32'(out_valid), 32'd0);
      check({nm, " released ready"}, 32'(in_ready), 32'd1);
      check({nm, " released busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic got;
    int lat, bcnt;
    logic seen;

    vecs[0]  = '{"shl1_7",      32'h0000_0007, 1'b0, 5'd1,  1'b0, 32'h0000_000E};
    vecs[1]  = '{"shr1_7",      32'h0000_0007, 1'b1, 5'd1,  1'b0, 32'h0000_0003};
    vecs[2]  = '{"amt0_3",      32'h0000_0003, 1'b0, 5'd0,  1'b0, 32'h0000_0003};
    vecs[3]  = '{"shl31_1",     32'h0000_0001, 1'b0, 5'd31, 1'b0, 32'h8000_0000};
    vecs[4]  = '{"shl31_ones",  32'hFFFF_FFFF, 1'b0, 5'd31, 1'b0, 32'h8000_0000};
    vecs[5]  = '{"sra4",        32'h8000_0000, 1'b1, 5'd4,  1'b1, 32'hF800_0000};
    vecs[6]  = '{"srl4",        32'h8000_0000, 1'b1, 5'd4,  1'b0, 32'h0800_0000};
    vecs[7]  = '{"sra8_a5",     32'hA5A5_A5A5, 1'b1, 5'd8,  1'b1, 32'hFFA5_A5A5};
    vecs[8]  = '{"shl4_a5",     32'hA5A5_A5A5, 1'b0, 5'd4,  1'b0, 32'h5A5A_5A50};
    vecs[9]  = '{"sra31_pos",   32'h7FFF_FFFF, 1'b1, 5'd31, 1'b1, 32'h0000_0000};
    vecs[10] = '{"srl31",       32'h8000_0001, 1'b1, 5'd31, 1'b0, 32'h0000_0001};
    vecs[11] = '{"amt0_right",  32'h1234_5678, 1'b1, 5'd0,  1'b1, 32'h1234_5678};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    in_amt = '0; in_arith = 1'b0; out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].name, vecs[i].data, vecs[i].dir, vecs[i].amt,
              vecs[i].arith, vecs[i].exp);
    end

    // backpressure: hold result 5 cycles while the next request waits
    out_ready = 1'b0;
    wait_ready("bp");
    in_valid = 1'b1; in_data = 32'h0000_00F0; in_dir = 1'b0; in_amt = 5'd2; in_arith = 1'b0;
    @(posedge clk);
    #1 in_data = 32'h0000_0011; in_amt = 5'd1;
    wait_valid(got, lat, bcnt);
    check("bp out_valid seen", 32'(got), 32'd1);
    check("bp first data", out_data, 32'h0000_03C0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold valid %0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold data %0d", i), out_data, 32'h0000_03C0);
      check($sformatf("bp hold in_ready %0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp released ready", 32'(in_ready), 32'd1);
    check("bp released valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(got, lat, bcnt);
    check("bp second seen", 32'(got), 32'd1);
    check("bp second data", out_data, 32'h0000_0022);
    check("bp second latency", 32'(lat), 32'd2);

    // reset during SHIFT: request is dropped
    wait_ready("rst_mid");
    in_valid = 1'b1; in_data = 32'h0000_FFFF; in_dir = 1'b0; in_amt = 5'd10; in_arith = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid in_ready during rst", 32'(in_ready), 32'd0);
    check("rst_mid out_valid during rst", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid out_data", out_data, 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid no out_valid", 32'(seen), 32'd0);
    run_req("after_rst", 32'h0000_0005, 1'b0, 5'd3, 1'b0, 32'h0000_0028);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_shift_engine.md
# serial_shift_engine

Multi-cycle shift stage directly downstream of the single-bit address shifter. Accepts a 32-bit address, a direction and a shift amount over a valid/ready handshake. Applies the one-bit left/right shift once per clock, `amt` times, and presents the result over a second valid/ready handshake. It is used where a variable shift distance is needed but a full barrel shifter is not justified.

## Interface
- `WIDTH`, 32: data/address width.
- `AMT_W`, 5: width of the shift-amount field; `WIDTH` must equal 2**`AMT_W`.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: engine can accept a request.
- `in_data` input `WIDTH`: value to shift.
- `in_dir` input 1: 0 = left shift, 1 = right shift (same encoding as the shifter stage).
- `in_amt` input `AMT_W`: number of one-bit shifts, 0..`WIDTH`-1.
- `in_arith` input 1: 1 = right shifts replicate the MSB; ignored for left shifts.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `out_data` output `WIDTH`: shifted result.
- `busy` output 1: request in flight (state not IDLE).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load `data_q`←`in_data`, `dir_q`, `arith_q`, `cnt_q`←`in_amt`.
  - Go to SHIFT if `in_amt`≠0, else DONE.
- SHIFT, one shift per cycle:
  - Left: `data_q`←`data_q`<<1, LSB 0.
  - Right: `data_q`←`data_q`>>1, MSB = `arith_q` ? old MSB : 0.
  - `cnt_q`←`cnt_q`−1.
  - When `cnt_q`==1 (last shift this cycle), go to DONE.
- DONE:
  - `out_valid`=1 and `out_data`=`data_q`, held stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `in_ready` is high only in IDLE; there is no request overlap or pipelining. `in_*` inputs are ignored outside IDLE.
- `out_data` is driven from `data_q` in all states. It is only meaningful while `out_valid`=1.
- No wrap-around: bits shifted out are lost and there is no rotate.
- `cnt_q` never underflows, because zero-amount requests bypass SHIFT.
- `busy` = (state≠IDLE).

## Timing
- Reset, applied at any edge with `rst`=1:
  - state=IDLE, `data_q`=0, `cnt_q`=0, `dir_q`=0, `arith_q`=0.
  - `out_valid`=0, `out_data`=0, `busy`=0.
- `in_ready` is 0 while `rst`=1 and 1 in the first cycle after release.
- Reset mid-operation, in SHIFT or DONE: the request is discarded and no `out_valid` pulse occurs. This holds even if `out_ready` is high in the same cycle.
- Latency: with acceptance at edge E0, `out_valid` is first high in the cycle after edge E0+`in_amt`.
  - `in_amt`=0: `out_valid` is high in the cycle immediately after acceptance.
  - `in_amt`=31: 31 SHIFT cycles.
- Throughput: one request per `in_amt`+2 cycles, when `out_ready` is held high.
- Output handshake completes on the edge where `out_valid`&&`out_ready`.
  - `in_ready` rises in the following cycle.
  - The next request is accepted at the earliest one edge later.
- `out_ready` high before `out_valid` is permitted and has no effect.
- All outputs are registered or decoded from the state register only. There is no combinational path from `in_*` or `out_ready` to any output.

## Test plan
- Left shift by 1:
  - Stimulus: `in_data`=7, `in_dir`=0, `in_amt`=1, `out_ready`=1.
  - Response: `out_data`=14; `out_valid` 1 cycle after E0+1; `busy` high 2 cycles.
- Right shift by 1:
  - Stimulus: `in_data`=7, `in_dir`=1, `in_amt`=1, `in_arith`=0.
  - Response: `out_data`=3.
  - Then `in_data`=3, `in_dir`=0, `in_amt`=0. Response: `out_data`=3 in the cycle after acceptance.
- Maximum amount:
  - Stimulus: `in_data`=1, `in_dir`=0, `in_amt`=31.
  - Response: `out_data`=0x8000_0000 exactly 31 shift cycles after acceptance.
  - Also `in_data`=0xFFFF_FFFF, `in_dir`=0, `in_amt`=31. Response: 0x8000_0000.
- Arithmetic versus logical right shift:
  - Stimulus: `in_data`=0x8000_0000, `in_dir`=1, `in_amt`=4.
  - Response: `in_arith`=1 gives 0xF800_0000; `in_arith`=0 gives 0x0800_0000.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after `out_valid` rises, with `in_valid` held high.
  - Response: `out_data` stable, `out_valid` stays 1, `in_ready` stays 0, and the second request is not accepted until the cycle after `out_ready`=1.
- Reset mid-SHIFT:
  - Stimulus: `in_amt`=10, assert `rst` for 1 cycle at shift 4.
  - Response: no `out_valid`; `out_data`=0, `busy`=0, `in_ready`=1 the cycle after release.
  - A new request then completes normally.
